// File: rtl/exp7_pkg.sv
// Shared definitions for the sequence display controller: state codes
// (also shown on the debug display) and the width of the on/off timer.
package exp7_pkg;

    // Timer width; the timer must hold T_ACESO-1 and T_APAGADO-1 (up to 65534).
    localparam int TIMER_W = 16;

    // State codes are fixed because they are shown on the hexa7seg display.
    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        PROXIMO = 4'd4,
        FIM     = 4'd5
    } estado_t;

endpackage

// File: rtl/contador_m.sv
// Generic up-counter with synchronous clear (priority) and count enable.
// Used as the on/off timer of the display controller.
module contador_m #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_zera,
    input  logic         i_conta,
    output logic [W-1:0] o_valor
);

    logic [W-1:0] r_valor;

    // Counter register: clear has priority over increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the edge.
        if (i_rst) begin
            r_valor <= '0;
        end else if (i_zera) begin
            r_valor <= '0;
        end else if (i_conta) begin
            r_valor <= r_valor + 1'b1;
        end
    end

    assign o_valor = r_valor;

endmodule

// File: rtl/exp7_controle_exibicao.sv
// Playback controller for the memorised LED sequence: lights each element
// for T_ACESO cycles, blanks for T_APAGADO cycles, then either advances the
// datapath address or finishes when the address reaches the sequence length.
// Optional feature: define EXP7_DB_ESTADO_EN to add the 4-bit db_estado port
// that exposes the current state code to the debug display.
module exp7_controle_exibicao
    import exp7_pkg::*;
#(
    parameter int T_ACESO   = 1000,
    parameter int T_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       abortar,
    input  logic       enderecoIgualSequencia,
    output logic       zeraE,
    output logic       contaE,
    output logic       leds_ativos,
    output logic       ocupado,
`ifdef EXP7_DB_ESTADO_EN
    output logic       fim_exibicao,
    output logic [3:0] db_estado
`else
    output logic       fim_exibicao
`endif
);

    // Last timer value of each phase; the timer is cleared on leaving a
    // phase, so it never wraps inside a state.
    localparam logic [TIMER_W-1:0] ULTIMO_ACESO   = TIMER_W'(T_ACESO - 1);
    localparam logic [TIMER_W-1:0] ULTIMO_APAGADO = TIMER_W'(T_APAGADO - 1);

    estado_t              r_estado;
    estado_t              w_proximo;
    logic                 w_zera_t;
    logic                 w_conta_t;
    logic [TIMER_W-1:0]   w_timer;

    // Phase timer, cleared and enabled by the FSM.
    contador_m #(
        .W (TIMER_W)
    ) u_timer (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_zera  (w_zera_t),
        .i_conta (w_conta_t),
        .o_valor (w_timer)
    );

    // State register; reset drops straight back to the idle state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    // Next-state, timer control and Moore outputs decoded from the state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        w_proximo    = r_estado;
        w_zera_t     = 1'b1;
        w_conta_t    = 1'b0;
        zeraE        = 1'b0;
        contaE       = 1'b0;
        leds_ativos  = 1'b0;
        ocupado      = 1'b1;
        fim_exibicao = 1'b0;

        case (r_estado)
            INICIAL: begin
                ocupado = 1'b0;
                if (iniciar) begin
                    w_proximo = PREPARA;
                end
            end
            PREPARA: begin
                zeraE     = 1'b1;
                w_proximo = ACENDE;
            end
            ACENDE: begin
                leds_ativos = 1'b1;
                if (w_timer == ULTIMO_ACESO) begin
                    w_proximo = APAGA;
                end else begin
                    w_zera_t  = 1'b0;
                    w_conta_t = 1'b1;
                end
            end
            APAGA: begin
                // The address flag only matters on the final blank cycle.
                if (w_timer == ULTIMO_APAGADO) begin
                    w_proximo = enderecoIgualSequencia ? FIM : PROXIMO;
                end else begin
                    w_zera_t  = 1'b0;
                    w_conta_t = 1'b1;
                end
            end
            PROXIMO: begin
                contaE    = 1'b1;
                w_proximo = ACENDE;
            end
            FIM: begin
                fim_exibicao = 1'b1;
                w_proximo    = INICIAL;
            end
            default: begin
                // Unused codes are not a playback state: report idle and recover.
                ocupado   = 1'b0;
                w_proximo = INICIAL;
            end
        endcase

        // Abort overrides every other transition outside the idle state.
        if (abortar && (r_estado != INICIAL)) begin
            w_proximo = INICIAL;
            w_zera_t  = 1'b1;
            w_conta_t = 1'b0;
        end
    end

`ifdef EXP7_DB_ESTADO_EN
    // State code straight to the debug display.
    assign db_estado = r_estado;
`endif

endmodule

// File: tb/tb_exp7_controle_exibicao.sv
// Self-checking bench for exp7_controle_exibicao with T_ACESO=4, T_APAGADO=2.
// Build with EXP7_DB_ESTADO_EN defined to also check the db_estado port.
module tb_exp7_controle_exibicao;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic       enderecoIgualSequencia;
    logic       zeraE;
    logic       contaE;
    logic       leds_ativos;
    logic       ocupado;
    logic       fim_exibicao;
`ifdef EXP7_DB_ESTADO_EN
    logic [3:0] db_estado;
`endif

    int n_cmp = 0;
    int n_err = 0;

    exp7_controle_exibicao #(
        .T_ACESO   (4),
        .T_APAGADO (2)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .iniciar                (iniciar),
        .abortar                (abortar),
        .enderecoIgualSequencia (enderecoIgualSequencia),
        .zeraE                  (zeraE),
        .contaE                 (contaE),
        .leds_ativos            (leds_ativos),
        .ocupado                (ocupado),
`ifdef EXP7_DB_ESTADO_EN
        .fim_exibicao           (fim_exibicao),
        .db_estado              (db_estado)
`else
        .fim_exibicao           (fim_exibicao)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One table record: inputs applied before an edge, Moore outputs after it.
    typedef struct packed {
        logic       ini;
        logic       abo;
        logic       eq;
        logic       z;
        logic       c;
        logic       l;
        logic       o;
        logic       f;
        logic [3:0] db;
    } vec_t;

    localparam int N_VEC = 19;
    vec_t tbl [N_VEC];

    // Results of the last playback run.
    int cnt_z, cnt_c, cnt_l, cnt_off, cnt_f, cnt_o, cnt_pulses;
    int pulse_min, pulse_max, cnt_multi;
    int timed_out;
    logic [3:0] trace [16];
    int n_trace;

    // Starts playback and runs until ocupado drops; eq rises once n_eq
    // contaE pulses have been seen.
    task automatic run_playback(input int n_eq);
        int run;
        cnt_z = 0; cnt_c = 0; cnt_l = 0; cnt_off = 0; cnt_f = 0; cnt_o = 0;
        cnt_pulses = 0; pulse_min = 1000; pulse_max = 0; cnt_multi = 0;
        timed_out = 1; n_trace = 0; run = 0;
`ifdef EXP7_DB_ESTADO_EN
        trace[n_trace] = db_estado;
`else
        trace[n_trace] = 4'd0;
`endif
        n_trace++;
        iniciar = 1'b1;
        enderecoIgualSequencia = (n_eq == 0);
        @(posedge clock); #1;
        iniciar = 1'b0;
        for (int k = 0; k < 100; k++) begin
`ifdef EXP7_DB_ESTADO_EN
            if (n_trace < 16) begin
                trace[n_trace] = db_estado;
                n_trace++;
            end
`endif
            cnt_z += int'(zeraE);
            cnt_c += int'(contaE);
            cnt_l += int'(leds_ativos);
            cnt_f += int'(fim_exibicao);
            cnt_o += int'(ocupado);
            if (ocupado && !leds_ativos && !zeraE && !contaE && !fim_exibicao) cnt_off++;
            if ((int'(zeraE) + int'(contaE) + int'(leds_ativos)) > 1) cnt_multi++;
            if (leds_ativos) begin
                run++;
            end else if (run > 0) begin
                cnt_pulses++;
                if (run < pulse_min) pulse_min = run;
                if (run > pulse_max) pulse_max = run;
                run = 0;
            end
            if (!ocupado) begin
                timed_out = 0;
                break;
            end
            enderecoIgualSequencia = (cnt_c >= n_eq);
            @(posedge clock); #1;
        end
        enderecoIgualSequencia = 1'b0;
    endtask

    task automatic check_one_element(input string tag);
        check({tag, " timeout"},       timed_out, 0);
        check({tag, " zeraE cycles"},  cnt_z, 1);
        check({tag, " leds cycles"},   cnt_l, 4);
        check({tag, " leds pulses"},   cnt_pulses, 1);
        check({tag, " off cycles"},    cnt_off, 2);
        check({tag, " fim pulses"},    cnt_f, 1);
        check({tag, " contaE cycles"}, cnt_c, 0);
        check({tag, " busy cycles"},   cnt_o, 8);
        check({tag, " overlap"},       cnt_multi, 0);
    endtask

    initial begin
        // {ini abo eq}_{zeraE contaE leds ocupado fim}_{db_estado}
        tbl[0]  = 12'b101_10010_0001; // start -> PREPARA
        tbl[1]  = 12'b001_00110_0010; // ACENDE t=0
        tbl[2]  = 12'b001_00110_0010;
        tbl[3]  = 12'b001_00110_0010;
        tbl[4]  = 12'b001_00110_0010; // ACENDE t=3 (4th lit cycle)
        tbl[5]  = 12'b001_00010_0011; // APAGA t=0
        tbl[6]  = 12'b001_00010_0011; // eq=1 on a non-final blank cycle: ignored
        tbl[7]  = 12'b000_01010_0100; // eq=0 on final blank cycle -> PROXIMO
        tbl[8]  = 12'b001_00110_0010; // ACENDE again
        tbl[9]  = 12'b001_00110_0010;
        tbl[10] = 12'b001_00110_0010;
        tbl[11] = 12'b001_00110_0010;
        tbl[12] = 12'b001_00010_0011; // APAGA
        tbl[13] = 12'b100_00010_0011; // iniciar during APAGA: ignored
        tbl[14] = 12'b001_00011_0101; // eq=1 on final blank cycle -> FIM
        tbl[15] = 12'b100_00000_0000; // FIM -> INICIAL regardless of iniciar
        tbl[16] = 12'b100_10010_0001; // iniciar held -> restart
        tbl[17] = 12'b010_00000_0000; // abort from PREPARA
        tbl[18] = 12'b000_00000_0000; // stay idle

        reset = 1'b1;
        iniciar = 1'b0;
        abortar = 1'b0;
        enderecoIgualSequencia = 1'b0;
        #1;
        check("reset zeraE", int'(zeraE), 0);
        check("reset contaE", int'(contaE), 0);
        check("reset leds", int'(leds_ativos), 0);
        check("reset ocupado", int'(ocupado), 0);
        check("reset fim", int'(fim_exibicao), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven cycle-by-cycle vectors.
        for (int i = 0; i < N_VEC; i++) begin
            iniciar = tbl[i].ini;
            abortar = tbl[i].abo;
            enderecoIgualSequencia = tbl[i].eq;
            @(posedge clock); #1;
            check($sformatf("vec%0d zeraE", i), int'(zeraE), int'(tbl[i].z));
            check($sformatf("vec%0d contaE", i), int'(contaE), int'(tbl[i].c));
            check($sformatf("vec%0d leds", i), int'(leds_ativos), int'(tbl[i].l));
            check($sformatf("vec%0d ocupado", i), int'(ocupado), int'(tbl[i].o));
            check($sformatf("vec%0d fim", i), int'(fim_exibicao), int'(tbl[i].f));
`ifdef EXP7_DB_ESTADO_EN
            check($sformatf("vec%0d db_estado", i), int'(db_estado), int'(tbl[i].db));
`endif
        end
        iniciar = 1'b0;
        abortar = 1'b0;
        enderecoIgualSequencia = 1'b0;
        @(posedge clock); #1;

        // One element.
        run_playback(0);
        check_one_element("one");
`ifdef EXP7_DB_ESTADO_EN
        begin
            logic [3:0] exp_db [10];
            exp_db = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd5, 4'd0};
            check("one db trace length", n_trace, 10);
            for (int i = 0; i < 10; i++) begin
                check($sformatf("one db_estado[%0d]", i), int'(trace[i]), int'(exp_db[i]));
            end
        end
`endif

        // Three elements: PREPARA + 2*(4+2+1) + (4+2) + FIM = 22 busy cycles,
        // of which 21 follow PREPARA.
        @(posedge clock); #1;
        run_playback(2);
        check("three timeout", timed_out, 0);
        check("three leds pulses", cnt_pulses, 3);
        check("three pulse min", pulse_min, 4);
        check("three pulse max", pulse_max, 4);
        check("three contaE cycles", cnt_c, 2);
        check("three off cycles", cnt_off, 6);
        check("three fim pulses", cnt_f, 1);
        check("three zeraE cycles", cnt_z, 1);
        check("three busy cycles", cnt_o, 22);
        check("three cycles after PREPARA", cnt_o - cnt_z, 21);
        check("three overlap", cnt_multi, 0);

        // Abort on the 2nd ACENDE cycle.
        @(posedge clock); #1;
        iniciar = 1'b1;
        @(posedge clock); #1;           // PREPARA
        iniciar = 1'b0;
        @(posedge clock); #1;           // ACENDE, 1st cycle
        @(posedge clock); #1;           // ACENDE, 2nd cycle
        check("abort pre leds", int'(leds_ativos), 1);
        abortar = 1'b1;
        @(posedge clock); #1;
        abortar = 1'b0;
        check("abort ocupado", int'(ocupado), 0);
        check("abort leds", int'(leds_ativos), 0);
        begin
            int fims = int'(fim_exibicao);
            int busy = int'(ocupado);
            repeat (10) begin
                @(posedge clock); #1;
                fims += int'(fim_exibicao);
                busy += int'(ocupado);
            end
            check("abort fim pulses", fims, 0);
            check("abort stays idle", busy, 0);
        end

        // Asynchronous reset in the middle of ACENDE.
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        @(posedge clock); #1;           // ACENDE
        check("areset pre leds", int'(leds_ativos), 1);
        #2;
        reset = 1'b1;
        #1;                             // still before the next rising edge
        check("areset leds", int'(leds_ativos), 0);
        check("areset ocupado", int'(ocupado), 0);
        check("areset zeraE", int'(zeraE), 0);
        check("areset contaE", int'(contaE), 0);
        check("areset fim", int'(fim_exibicao), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        begin
            int busy = 0;
            repeat (5) begin
                @(posedge clock); #1;
                busy += int'(ocupado);
            end
            check("areset needs iniciar", busy, 0);
        end
        run_playback(0);
        check_one_element("after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
